// File: rtl/seg7_entry.sv
// seg7_entry: four-digit hex entry panel driven by five push buttons.
// Buttons are synchronized and debounced on the 1 ms tick. Debounced press
// edges drive a small IDLE/EDIT/COMMIT editor that shows either the committed
// value or the edit buffer on a 4-digit seven-segment code bus.
//
// Handshake: O_VALID is a single-cycle pulse that qualifies O_VALUE; there is
// no ready/backpressure, and the consumer must capture O_VALUE in that cycle.
module seg7_entry #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TICK_1MS,
  input  logic        I_BTN_UP,
  input  logic        I_BTN_DOWN,
  input  logic        I_BTN_LEFT,
  input  logic        I_BTN_RIGHT,
  input  logic        I_BTN_ENTER,
  output logic [19:0] O_SEG7DATA,
  output logic [3:0]  O_SEG7BLINK,
  output logic [15:0] O_VALUE,
  output logic        O_VALID,
  output logic        O_EDITING,
  output logic [1:0]  O_DBG_STATE
);

  localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);

  // Button bit order: 4 ENTER, 3 UP, 2 DOWN, 1 LEFT, 0 RIGHT (priority high->low)
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync2_q;
  logic [4:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [4:0]    press;

  state_e        state_q, state_d;
  logic [1:0]    cursor_q, cursor_d;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   value_q, value_d;
  logic          valid_q, valid_d;
  logic [19:0]   seg_q, seg_d;
  logic [3:0]    blink_q, blink_d;
  logic          editing_q, editing_d;
  logic [15:0]   disp;
  logic [3:0]    cur_nib;

  assign btn_raw = {I_BTN_ENTER, I_BTN_UP, I_BTN_DOWN, I_BTN_LEFT, I_BTN_RIGHT};

  // Two-flop synchronizer on every raw button
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count ticks while the level disagrees, accept after DEBOUNCE_MS
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (TICK_1MS) begin
        if (cnt_q[i] == CW'(DEBOUNCE_MS - 1)) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A press event is the cycle in which the debounced level rises
  assign press = deb_d & ~deb_q;

  // Debounced level and counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Editor next state plus registered outputs derived from the next state
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    buf_d    = buf_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    cur_nib  = buf_q[{cursor_q, 2'b00} +: 4];
    unique case (state_q)
      ST_IDLE: begin
        if (press[4]) begin
          state_d  = ST_EDIT;
          buf_d    = value_q;
          cursor_d = 2'd0;
        end
      end
      ST_EDIT: begin
        if (press[4]) begin
          state_d = ST_COMMIT;
          value_d = buf_q;
          valid_d = 1'b1;
        end else if (press[3]) begin
          buf_d[{cursor_q, 2'b00} +: 4] = cur_nib + 4'd1;
        end else if (press[2]) begin
          buf_d[{cursor_q, 2'b00} +: 4] = cur_nib - 4'd1;
        end else if (press[1]) begin
          cursor_d = cursor_q + 2'd1;
        end else if (press[0]) begin
          cursor_d = cursor_q - 2'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    disp = (state_d == ST_IDLE) ? value_d : buf_d;
    for (int i = 0; i < 4; i++) seg_d[5*i +: 5] = {1'b0, disp[4*i +: 4]};
    blink_d   = (state_d == ST_EDIT) ? (4'b0001 << cursor_d) : 4'b0000;
    editing_d = (state_d == ST_EDIT);
  end

  // Editor state and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cursor_q  <= '0;
      buf_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      seg_q     <= '0;
      blink_q   <= '0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      buf_q     <= buf_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      seg_q     <= seg_d;
      blink_q   <= blink_d;
      editing_q <= editing_d;
    end
  end

  assign O_SEG7DATA  = seg_q;
  assign O_SEG7BLINK = blink_q;
  assign O_VALUE     = value_q;
  assign O_VALID     = valid_q;
  assign O_EDITING   = editing_q;
  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_seg7_entry.sv
// Bench for seg7_entry: stimulus pushes predicted output snapshots into a
// queue, a monitor pops one snapshot every time the DUT outputs change.
`timescale 1ns/1ps
module tb_seg7_entry;

  localparam int DB = 20;
  localparam logic [4:0] B_ENTER = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_enter = 1'b0;
  logic [19:0] seg;
  logic [3:0]  blink;
  logic [15:0] value;
  logic        valid, editing;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  seg7_entry #(.DEBOUNCE_MS(DB)) dut (
    .CLK(clk), .RST(rst), .TICK_1MS(tick),
    .I_BTN_UP(b_up), .I_BTN_DOWN(b_down), .I_BTN_LEFT(b_left),
    .I_BTN_RIGHT(b_right), .I_BTN_ENTER(b_enter),
    .O_SEG7DATA(seg), .O_SEG7BLINK(blink), .O_VALUE(value),
    .O_VALID(valid), .O_EDITING(editing), .O_DBG_STATE(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [41:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int n_pop = 0;
  int n_valid_cyc = 0;
  bit mon_en = 1'b0;
  logic [41:0] mon_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] dut_t();
    return {seg, blink, value, valid, editing};
  endfunction

  function automatic logic [41:0] mk(input logic [15:0] disp, input logic [3:0] bl,
                                     input logic [15:0] v, input logic vl, input logic ed);
    logic [19:0] s;
    for (int i = 0; i < 4; i++) s[5*i +: 5] = {1'b0, disp[4*i +: 4]};
    return {s, bl, v, vl, ed};
  endfunction

  // Monitor: every output change must match the next predicted snapshot
  always @(negedge clk) begin
    if (mon_en) begin
      logic [41:0] t;
      t = dut_t();
      if (valid === 1'b1) n_valid_cyc++;
      if (t !== mon_prev) begin
        n_pop++;
        if (exp_q.size() == 0) chk("unexpected_output_change", t, mon_prev);
        else chk("output_snapshot", t, exp_q.pop_front());
        mon_prev = t;
      end
    end
  end

  // ---------------- reference model ----------------
  int m_mode = 0;          // 0 idle, 1 edit
  int m_cur = 0;
  int m_nib[4] = '{0, 0, 0, 0};
  int m_val = 0;
  logic [41:0] m_t = '0;

  function automatic logic [15:0] m_buf();
    return 16'(m_nib[3] * 4096 + m_nib[2] * 256 + m_nib[1] * 16 + m_nib[0]);
  endfunction

  task automatic push_if_diff(input logic [41:0] t);
    if (t !== m_t) begin
      exp_q.push_back(t);
      m_t = t;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_val = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = 0;
    push_if_diff('0);
  endtask

  task automatic model_event(input logic [4:0] m);
    if (m_mode == 0) begin
      if (m[4]) begin
        m_mode = 1; m_cur = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = (m_val >> (4 * i)) % 16;
        push_if_diff(mk(m_buf(), 4'(1 << m_cur), 16'(m_val), 1'b0, 1'b1));
      end
    end else begin
      if (m[4]) begin
        m_val = int'(m_buf());
        push_if_diff(mk(m_buf(), 4'b0000, 16'(m_val), 1'b1, 1'b0));
        m_mode = 0;
        push_if_diff(mk(16'(m_val), 4'b0000, 16'(m_val), 1'b0, 1'b0));
      end else begin
        if (m[3])      m_nib[m_cur] = (m_nib[m_cur] + 1) % 16;
        else if (m[2]) m_nib[m_cur] = (m_nib[m_cur] + 15) % 16;
        else if (m[1]) m_cur = (m_cur + 1) % 4;
        else if (m[0]) m_cur = (m_cur + 3) % 4;
        push_if_diff(mk(m_buf(), 4'(1 << m_cur), 16'(m_val), 1'b0, 1'b1));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_btn(input logic [4:0] m);
    @(posedge clk); #1;
    {b_enter, b_up, b_down, b_left, b_right} = m;
    repeat (3) @(posedge clk);
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  task automatic press(input logic [4:0] m);
    model_event(m);
    set_btn(m);
    tick_n(DB);
    set_btn(5'b0);
    tick_n(DB);
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Held level must be accepted on exactly the DB-th tick, not before
  task automatic expect_on_last_tick(input string name);
    int p0;
    p0 = n_pop;
    tick_n(DB - 1);
    repeat (4) @(posedge clk);
    chk({name, "_before_last_tick"}, n_pop, p0);
    tick_n(1);
    repeat (4) @(posedge clk);
    chk({name, "_on_last_tick"}, n_pop, p0 + 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    n_vec++;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got %0d pending expected 0", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    logic [19:0] seg_exp;
    logic [4:0] m;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", seg, 20'h0);
    chk("reset_blink", blink, 4'h0);
    chk("reset_value", value, 16'h0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_editing", editing, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    // Entry sequence 00E3
    press(B_ENTER);
    repeat (3) press(B_UP);
    press(B_LEFT);
    repeat (2) press(B_DOWN);
    v0 = n_valid_cyc;
    press(B_ENTER);
    chk("commit_value_00e3", value, 16'h00E3);
    seg_exp = {5'h00, 5'h00, 5'h0E, 5'h03};
    chk("commit_seg_00e3", seg, seg_exp);
    chk("commit_valid_width", n_valid_cyc - v0, 1);
    chk("idle_editing_low", editing, 1'b0);

    // Cursor wrap in both directions
    press(B_ENTER);
    chk("edit_blink_cursor0", blink, 4'b0001);
    press(B_RIGHT);
    chk("blink_after_right_wrap", blink, 4'b1000);
    press(B_LEFT);
    chk("blink_after_left_wrap", blink, 4'b0001);

    // ENTER beats UP in the same cycle
    press(B_ENTER | B_UP);
    chk("enter_over_up_value", value, 16'h00E3);

    // Bouncing UP inside EDIT: only the stable stretch produces an event
    press(B_ENTER);
    model_event(B_UP);
    for (int s = 0; s < 12; s++) begin
      set_btn((s % 2 == 0) ? B_UP : 5'b0);
      tick_n(5);
    end
    set_btn(B_UP);
    expect_on_last_tick("bounce_up");
    set_btn(5'b0);
    tick_n(DB);
    repeat (4) @(posedge clk);
    press(B_ENTER);
    chk("bounce_single_increment", value, 16'h00E4);

    // Reset in the middle of editing 1234
    do_reset();
    press(B_ENTER);
    for (int d = 0; d < 4; d++) begin
      repeat (4 - d) press(B_UP);
      if (d < 3) press(B_LEFT);
    end
    v0 = n_valid_cyc;
    do_reset();
    chk("midedit_reset_value", value, 16'h0);
    chk("midedit_reset_blink", blink, 4'h0);
    chk("midedit_reset_no_valid", n_valid_cyc - v0, 0);

    // Build ABCD, then UP/LEFT in IDLE must leave outputs alone
    press(B_ENTER);
    for (int d = 0; d < 4; d++) begin
      repeat (3 + d) press(B_DOWN);
      if (d < 3) press(B_LEFT);
    end
    press(B_ENTER);
    press(B_UP);
    press(B_LEFT);
    seg_exp = {5'h0A, 5'h0B, 5'h0C, 5'h0D};
    chk("idle_ignore_seg_abcd", seg, seg_exp);
    chk("idle_ignore_value_abcd", value, 16'hABCD);

    // Button held through reset release: one event after DB ticks
    model_reset();
    model_event(B_ENTER);
    set_btn(B_ENTER);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    expect_on_last_tick("held_through_reset");
    chk("held_reset_editing", editing, 1'b1);
    set_btn(5'b0);
    tick_n(DB);
    repeat (4) @(posedge clk);

    // Randomized event mix
    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 99) < 4) begin
        do_reset();
      end else begin
        m = 5'(1 << $urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) m = m | 5'(1 << $urandom_range(0, 4));
        press(m);
      end
    end

    repeat (10) @(posedge clk);
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
